// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and a
// combinational fetch lookup. Define BTP_GSHARE_EN to XOR a global history register into the index.
module branch_target_predictor #(
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_hit,
  output logic             lookup_taken,
  output logic [31:0]      lookup_target,
  output logic [IDX_W-1:0] lookup_hist,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic [IDX_W-1:0] upd_hist
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [31:0]      tgt_q   [DEPTH];
  logic [31:0]      tgt_d   [DEPTH];
  logic [CNT_W-1:0] cnt_q   [DEPTH];
  logic [CNT_W-1:0] cnt_d   [DEPTH];

  logic [IDX_W-1:0] hist_src;
  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] u_tag;
  logic             l_hit;
  logic             u_hit;
  logic             unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

`ifdef BTP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;
  logic [IDX_W:0]   ghr_shift;

  assign ghr_shift = {ghr_q, upd_taken};
  assign ghr_d     = upd_valid ? ghr_shift[IDX_W-1:0] : ghr_q;
  assign hist_src  = ghr_q;
  assign u_idx     = upd_pc[IDX_W+1:2] ^ upd_hist;

  always_ff @(posedge CLK) begin
    if (RST) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  assign hist_src    = '0;
  assign u_idx       = upd_pc[IDX_W+1:2];
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_hist};
`endif

  assign l_idx = lookup_pc[IDX_W+1:2] ^ hist_src;
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Outputs are forced quiet while RST is high, since the table still holds pre-reset contents.
  assign lookup_hit    = !RST && l_hit;
  assign lookup_taken  = !RST && l_hit && cnt_q[l_idx][CNT_W-1];
  assign lookup_target = (!RST && l_hit) ? tgt_q[l_idx] : 32'h0;
  assign lookup_hist   = RST ? '0 : hist_src;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          cnt_d[u_idx] = sat_inc(cnt_q[u_idx]);
          tgt_d[u_idx] = upd_target;
        end else begin
          cnt_d[u_idx] = sat_dec(cnt_q[u_idx]);
        end
      end else if (upd_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target;
        cnt_d[u_idx]   = CNT_WEAK;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '{default: 1'b0};
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus randomized traffic
// against an array-based reference of the BTB rules.
module tb_branch_target_predictor;
  localparam int DEPTH = 16;
  localparam int CNT_W = 2;
  localparam int IDX_W = 4;
  localparam int OBS_W = 34 + IDX_W;

  logic             CLK = 1'b0;
  logic             RST;
  logic [31:0]      lookup_pc;
  logic             lookup_hit;
  logic             lookup_taken;
  logic [31:0]      lookup_target;
  logic [IDX_W-1:0] lookup_hist;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic [IDX_W-1:0] upd_hist;

  int errors = 0;
  int checks = 0;

  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  int unsigned m_tgt   [DEPTH];
  int          m_cnt   [DEPTH];
  int          m_ghr;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] exp_v;

  branch_target_predictor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .lookup_pc(lookup_pc), .lookup_hit(lookup_hit), .lookup_taken(lookup_taken),
    .lookup_target(lookup_target), .lookup_hist(lookup_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_hist(upd_hist)
  );

  always #5 CLK = ~CLK;
  assign obs = {lookup_hit, lookup_taken, lookup_target, lookup_hist};

  function automatic int m_index(input logic [31:0] pc, input int hist);
`ifdef BTP_GSHARE_EN
    return int'(((pc >> 2) ^ hist) % DEPTH);
`else
    return int'((pc >> 2) % DEPTH);
`endif
  endfunction

  function automatic logic [OBS_W-1:0] m_look(input logic [31:0] pc);
    int  h;
    int  i;
    bit  hit;
    bit  tk;
`ifdef BTP_GSHARE_EN
    h = m_ghr;
`else
    h = 0;
`endif
    i   = m_index(pc, h);
    hit = m_valid[i] && (m_tag[i] == (pc >> (2 + IDX_W)));
    tk  = hit && (m_cnt[i] >= 2 ** (CNT_W - 1));
    return {hit, tk, hit ? 32'(m_tgt[i]) : 32'h0, IDX_W'(h)};
  endfunction

  task automatic model_edge();
    int i;
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0;
      end
      m_ghr = 0;
    end else if (upd_valid) begin
      i = m_index(upd_pc, int'(upd_hist));
      if (m_valid[i] && m_tag[i] == (upd_pc >> (2 + IDX_W))) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] + 1 > 2 ** CNT_W - 1) ? 2 ** CNT_W - 1 : m_cnt[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = upd_pc >> (2 + IDX_W);
        m_tgt[i]   = upd_target;
        m_cnt[i]   = 2 ** (CNT_W - 1);
      end
      m_ghr = ((m_ghr << 1) | int'(upd_taken)) % DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic [IDX_W-1:0] h);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_hist = h;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    lookup_pc = 32'h40;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_high: got %h want 0", obs);
    end
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_after: got %h want 0", obs);
    end
  endtask

  task automatic test_alloc();
    lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, '0);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL alloc_pre: got %h want 0", obs);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    #1;
    exp_v = m_look(lookup_pc);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL alloc_model: got %h want %h", obs, exp_v);
    end
`ifndef BTP_GSHARE_EN
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h100, 4'h0}) begin
      errors++; $display("FAIL alloc_const: got %h want hit=1 taken=1 tgt=100", obs);
    end
`endif
  endtask

  task automatic test_saturate();
    lookup_pc = 32'h40;
    for (int n = 0; n < 3; n++) begin
      set_upd(1'b1, 32'h40, 1'b0, 32'hdead_0000, '0);
      #1;
      exp_v = m_look(lookup_pc);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL sat_down_%0d: got %h want %h", n, obs, exp_v);
      end
      tick();
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    #1;
`ifndef BTP_GSHARE_EN
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h100, 4'h0}) begin
      errors++; $display("FAIL sat_floor: got %h want hit=1 taken=0 tgt=100", obs);
    end
`endif
    for (int n = 0; n < 2; n++) begin
      set_upd(1'b1, 32'h40, 1'b1, 32'h104, '0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
      #1;
      exp_v = m_look(lookup_pc);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL sat_up_%0d: got %h want %h", n, obs, exp_v);
      end
`ifndef BTP_GSHARE_EN
      checks++;
      if (obs !== {1'b1, (n == 1), 32'h104, 4'h0}) begin
        errors++; $display("FAIL sat_up_const_%0d: got %h want taken=%0d tgt=104", n, obs, n == 1);
      end
`endif
    end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h80, 1'b1, 32'h200, '0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    lookup_pc = 32'h40;
    #1;
    exp_v = m_look(lookup_pc);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL alias_old: got %h want %h", obs, exp_v);
    end
    lookup_pc = 32'h80;
    #1;
    exp_v = m_look(lookup_pc);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL alias_new: got %h want %h", obs, exp_v);
    end
`ifndef BTP_GSHARE_EN
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h200, 4'h0}) begin
      errors++; $display("FAIL alias_const: got %h want hit=1 tgt=200", obs);
    end
`endif
  endtask

  task automatic test_same_cycle();
    lookup_pc = 32'h44;
    set_upd(1'b1, 32'h44, 1'b1, 32'h300, '0);
    #1;
    checks++;
    if (lookup_hit !== 1'b0) begin
      errors++; $display("FAIL same_cycle_pre: hit got %b want 0", lookup_hit);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    #1;
    exp_v = m_look(lookup_pc);
    checks++;
    if (obs !== exp_v || lookup_hit !== 1'b1) begin
      errors++; $display("FAIL same_cycle_post: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_upd();
    lookup_pc = 32'h44;
    RST = 1'b1;
    set_upd(1'b1, 32'h48, 1'b1, 32'h400, '0);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL rst_upd_during: got %h want 0", obs);
    end
    tick();
    RST = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    for (int n = 0; n < 2; n++) begin
      lookup_pc = (n == 0) ? 32'h44 : 32'h48;
      #1;
      checks++;
      if (obs !== '0) begin
        errors++; $display("FAIL rst_upd_after_%0d: got %h want 0", n, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 600; n++) begin
      RST       = ($urandom_range(0, 59) == 0);
      lookup_pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
                  32'($urandom_range(0, 3));
      set_upd(($urandom_range(0, 3) != 0),
              (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2),
              $urandom_range(0, 1) == 1,
              $urandom & 32'hffff_fffc,
              IDX_W'($urandom_range(0, DEPTH - 1)));
      #1;
      exp_v = RST ? '0 : m_look(lookup_pc);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rand_%0d: pc=%h got %h want %h", n, lookup_pc, obs, exp_v);
      end
      tick();
    end
    RST = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
  endtask

`ifdef BTP_GSHARE_EN
  task automatic test_gshare();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_upd(1'b1, 32'h58, 1'b1, 32'h300, 4'h0);
    tick();
    set_upd(1'b1, 32'h1000, 1'b1, 32'h500, 4'h0);
    tick();
    set_upd(1'b1, 32'h2000, 1'b0, 32'h600, 4'h0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, '0);
    lookup_pc = 32'h40;
    #1;
    checks++;
    if (lookup_hist !== 4'b0110) begin
      errors++; $display("FAIL gshare_hist: got %h want 6", lookup_hist);
    end
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h300, 4'h6}) begin
      errors++; $display("FAIL gshare_entry: got %h want hit=1 tgt=300 hist=6", obs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_reset_upd();
    test_back_to_back();
`ifdef BTP_GSHARE_EN
    test_gshare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
